rc4_swap_engine: RTL and testbench
==================================

RC4_SWAP_ENGINE -- requirements
Module: rc4_swap_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width (S-box index width).
REQ-002 SHALL have parameter DATA_W, default 8, RAM word width.
REQ-003 SHALL have parameter RD_LAT, default 2, RAM read latency in cycles (legal range 1..4).
REQ-004 SHALL have parameter SKIP_SAME, default 1, 1 = no RAM writes when idx_i == idx_j.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request a swap; sampled only in IDLE.
REQ-008 SHALL have port idx_i  input  ADDR_W  first index; latched when start is accepted.
REQ-009 SHALL have port idx_j  input  ADDR_W  second index; latched when start is accepted.
REQ-010 SHALL have port rdata  input  DATA_W  RAM read data, valid RD_LAT cycles after addr.
REQ-011 SHALL have port addr  output  ADDR_W  RAM address.
REQ-012 SHALL have port wdata  output  DATA_W  RAM write data.
REQ-013 SHALL have port wren  output  1  RAM write enable.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port val_i  output  DATA_W  original s[i], registered.
REQ-017 SHALL have port val_j  output  DATA_W  original s[j], registered.
REQ-018 SHALL have port sum_out  output  DATA_W  (val_i + val_j) mod 2^DATA_W, for keystream lookup.

Function
REQ-019 SHALL implement states IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE.
REQ-020 SHALL, in IDLE with start=1 at edge k, latch idx_i/idx_j and be in RD_I during cycle k+1; start=0 stays IDLE.
REQ-021 SHALL drive addr=latched i in RD_I and WAIT_I, addr=latched j in RD_J and WAIT_J.
REQ-022 SHALL stay in WAIT_I (and WAIT_J) for exactly RD_LAT cycles via a down-counter; at the edge ending the last wait cycle capture rdata into val_i (val_j).
REQ-023 SHALL, in WR_I, drive addr=i, wdata=val_j, wren=1; in WR_J, drive addr=j, wdata=val_i, wren=1.
REQ-024 SHALL hold wren=0 in every state other than WR_I and WR_J.
REQ-025 SHALL assert done=1 only in DONE (one cycle), then return to IDLE; DONE at cycle k+5+2*RD_LAT (k+9 for RD_LAT=2).
REQ-026 SHALL, when SKIP_SAME=1 and i==j, go WAIT_I -> DONE, set val_j=val_i, issue no writes; DONE at cycle k+2+RD_LAT.
REQ-027 SHALL, when SKIP_SAME=0 and i==j, run the full sequence (writes same value twice).
REQ-028 SHALL ignore start while busy=1, including during DONE; inputs idx_i/idx_j may change after acceptance without effect.
REQ-029 SHALL compute sum_out with DATA_W-bit wrap-around; sum_out, val_i, val_j stable from DONE until next accepted start.
REQ-030 SHALL hold addr at latched i and wdata unchanged in IDLE (no X/Z outputs in any state).

Reset
REQ-031 SHALL, on reset=1 at any edge, enter IDLE with busy=0, done=0, wren=0, addr=0, wdata=0, val_i=0, val_j=0, sum_out=0, wait counter=0.
REQ-032 SHALL take priority of reset over start; reset mid-swap aborts with no further writes (a completed WR_I is not undone).
REQ-033 SHALL accept a new start on the first edge after reset deasserts.

Verification
REQ-034 SHALL cover basic swap: RAM s[3]=0x50, s[7]=0x12, RD_LAT=2, start i=3,j=7 -> done at k+9, s[3]=0x12, s[7]=0x50, sum_out=0x62, exactly 2 wren cycles.
REQ-035 SHALL cover wrap: s[0]=0xF0, s[255]=0x20 -> swapped, sum_out=0x10.
REQ-036 SHALL cover same index: SKIP_SAME=1, i=j=5, s[5]=0x33 -> done at k+4, wren never high, val_i=val_j=0x33, sum_out=0x66.
REQ-037 SHALL cover start while busy: second start pulse with i=1,j=2 at k+3 -> ignored, only original indices written, single done pulse.
REQ-038 SHALL cover reset in WAIT_J: reset at k+5 -> next cycle IDLE, all outputs at reset values, RAM unchanged.
REQ-039 SHALL cover RD_LAT=1 and RD_LAT=4 builds: done at k+7 and k+13 respectively with correct swap.

Source files
------------

// File: rtl/rc4_swap_engine.sv
// ---------------------------------------------------------------------------
// rc4_swap_engine
//
// Swaps two entries of an external S-box RAM, i.e. s[i] <-> s[j], as used by
// the RC4 key schedule and keystream generator. The engine reads s[i], then
// s[j]. Each read waits RD_LAT cycles for the RAM. It then writes the two
// values back crossed over. The original values and their 8-bit wrapped sum
// stay on val_i / val_j / sum_out for the keystream lookup.
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high
//   start    in   swap request, only looked at while idle
//   idx_i    in   first S-box index, latched on an accepted start
//   idx_j    in   second S-box index, latched on an accepted start
//   rdata    in   RAM read data, valid RD_LAT cycles after addr
//   addr     out  RAM address
//   wdata    out  RAM write data
//   wren     out  RAM write enable
//   busy     out  high whenever the engine is not idle
//   done     out  one-cycle completion pulse
//   val_i    out  original s[i]
//   val_j    out  original s[j]
//   sum_out  out  (val_i + val_j) mod 2^DATA_W
//
// Parameters: ADDR_W, DATA_W, RD_LAT (1..4), SKIP_SAME (1 = no writes when
// i == j).
// ---------------------------------------------------------------------------
module rc4_swap_engine #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 2,
    parameter int SKIP_SAME = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [ADDR_W-1:0] idx_j,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] val_i,
    output logic [DATA_W-1:0] val_j,
    output logic [DATA_W-1:0] sum_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_I   = 3'd1,
        S_WAIT_I = 3'd2,
        S_RD_J   = 3'd3,
        S_WAIT_J = 3'd4,
        S_WR_I   = 3'd5,
        S_WR_J   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // Wide enough for RD_LAT up to 4. The counter is loaded with RD_LAT-1 on
    // entry to a wait state, so the wait lasts exactly RD_LAT cycles.
    localparam int               CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_i_q, idx_i_d;
    logic [ADDR_W-1:0] idx_j_q, idx_j_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] val_i_q, val_i_d;
    logic [DATA_W-1:0] val_j_q, val_j_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_i_q <= '0;
            idx_j_q <= '0;
            cnt_q   <= '0;
            val_i_q <= '0;
            val_j_q <= '0;
        end else begin
            state_q <= state_d;
            idx_i_q <= idx_i_d;
            idx_j_q <= idx_j_d;
            cnt_q   <= cnt_d;
            val_i_q <= val_i_d;
            val_j_q <= val_j_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_i_d = idx_i_q;
        idx_j_d = idx_j_q;
        cnt_d   = cnt_q;
        val_i_d = val_i_q;
        val_j_d = val_j_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_i_d = idx_i;
                    idx_j_d = idx_j;
                    state_d = S_RD_I;
                end
            end
            S_RD_I: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT_I;
            end
            S_WAIT_I: begin
                if (cnt_q == '0) begin
                    val_i_d = rdata;
                    // With identical indices the swap is a no-op, so skip
                    // the second read and both writes.
                    if ((SKIP_SAME != 0) && (idx_i_q == idx_j_q)) begin
                        val_j_d = rdata;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_J;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RD_J: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT_J;
            end
            S_WAIT_J: begin
                if (cnt_q == '0) begin
                    val_j_d = rdata;
                    state_d = S_WR_I;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_I:  state_d = S_WR_J;
            S_WR_J:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs. addr falls back to the latched i in every state that does not
    // target j, which keeps it at i while idle.
    always_comb begin
        addr  = idx_i_q;
        wdata = val_j_q;
        wren  = 1'b0;
        case (state_q)
            S_RD_J, S_WAIT_J: addr = idx_j_q;
            S_WR_I: begin
                wdata = val_j_q;
                wren  = 1'b1;
            end
            S_WR_J: begin
                addr  = idx_j_q;
                wdata = val_i_q;
                wren  = 1'b1;
            end
            default: ;
        endcase
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        val_i   = val_i_q;
        val_j   = val_j_q;
        sum_out = val_i_q + val_j_q;
    end

endmodule

// File: tb/tb_rc4_swap_engine.sv
// ---------------------------------------------------------------------------
// tb_rc4_swap_engine
//
// Three engines share one clock. Each one has its own S-box RAM model with
// the matching read latency:
//   g=0 : RD_LAT=2, SKIP_SAME=1
//   g=1 : RD_LAT=1, SKIP_SAME=1
//   g=2 : RD_LAT=4, SKIP_SAME=0
// Directed vectors come from a table. Reset behaviour is a hand-written
// sequence. Random swaps are predicted from a plain array model of the
// S-box.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rc4_swap_engine;

    localparam int NG = 3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     [NG];
    logic       start   [NG];
    logic [7:0] idx_i   [NG];
    logic [7:0] idx_j   [NG];
    logic [7:0] rdata   [NG];
    logic [7:0] addr    [NG];
    logic [7:0] wdata   [NG];
    logic       wren    [NG];
    logic       busy    [NG];
    logic       done    [NG];
    logic [7:0] val_i   [NG];
    logic [7:0] val_j   [NG];
    logic [7:0] sum_out [NG];

    // RAM models plus the bench's own expected S-box contents.
    logic [7:0] mem    [NG][256];
    logic [7:0] pipe   [NG][4];
    logic [7:0] smodel [NG][256];
    logic       ld_en = 1'b0;
    int         ld_g  = 0;
    logic [7:0] ld_a  = '0;
    logic [7:0] ld_d  = '0;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 4;
    endfunction

    function automatic bit skip_of(input int g);
        return (g != 2);
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < NG; g++) begin
            pipe[g][0] <= mem[g][addr[g]];
            for (int p = 1; p < 4; p++) pipe[g][p] <= pipe[g][p-1];
            if (wren[g]) mem[g][addr[g]] <= wdata[g];
        end
        if (ld_en) mem[ld_g][ld_a] <= ld_d;
    end

    always_comb begin
        for (int g = 0; g < NG; g++) rdata[g] = pipe[g][lat_of(g)-1];
    end

    rc4_swap_engine #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2), .SKIP_SAME(1)) u_dut0 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .idx_i(idx_i[0]), .idx_j(idx_j[0]),
        .rdata(rdata[0]), .addr(addr[0]), .wdata(wdata[0]), .wren(wren[0]), .busy(busy[0]),
        .done(done[0]), .val_i(val_i[0]), .val_j(val_j[0]), .sum_out(sum_out[0]));

    rc4_swap_engine #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .SKIP_SAME(1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .idx_i(idx_i[1]), .idx_j(idx_j[1]),
        .rdata(rdata[1]), .addr(addr[1]), .wdata(wdata[1]), .wren(wren[1]), .busy(busy[1]),
        .done(done[1]), .val_i(val_i[1]), .val_j(val_j[1]), .sum_out(sum_out[1]));

    rc4_swap_engine #(.ADDR_W(8), .DATA_W(8), .RD_LAT(4), .SKIP_SAME(0)) u_dut2 (
        .clk(clk), .reset(rst[2]), .start(start[2]), .idx_i(idx_i[2]), .idx_j(idx_j[2]),
        .rdata(rdata[2]), .addr(addr[2]), .wdata(wdata[2]), .wren(wren[2]), .busy(busy[2]),
        .done(done[2]), .val_i(val_i[2]), .val_j(val_j[2]), .sum_out(sum_out[2]));

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic poke(input int g, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_g = g; ld_a = a; ld_d = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
        smodel[g][a] = d;
    endtask

    task automatic check_reset_outputs(input int g, input string tag);
        chk($sformatf("%s g%0d busy", tag, g), int'(busy[g]), 0);
        chk($sformatf("%s g%0d done", tag, g), int'(done[g]), 0);
        chk($sformatf("%s g%0d wren", tag, g), int'(wren[g]), 0);
        chk($sformatf("%s g%0d addr", tag, g), int'(addr[g]), 0);
        chk($sformatf("%s g%0d wdata", tag, g), int'(wdata[g]), 0);
        chk($sformatf("%s g%0d val_i", tag, g), int'(val_i[g]), 0);
        chk($sformatf("%s g%0d val_j", tag, g), int'(val_j[g]), 0);
        chk($sformatf("%s g%0d sum_out", tag, g), int'(sum_out[g]), 0);
    endtask

    // Must be entered at a falling edge. Start is sampled at the next rising
    // edge (edge k). Cycle n is the cycle following edge k+n-1.
    task automatic run_swap(input int g, input logic [7:0] i, input logic [7:0] j,
                            input bit pulse, input int exp_done, input int exp_wr,
                            input logic [7:0] exp_vi, input logic [7:0] exp_vj,
                            input logic [7:0] exp_sum, input logic [7:0] exp_mi,
                            input logic [7:0] exp_mj, input string tag);
        int done_at, ndone, nwr, bad_addr, busy_low;
        done_at = 0; ndone = 0; nwr = 0; bad_addr = 0; busy_low = 0;
        start[g] = 1'b1; idx_i[g] = i; idx_j[g] = j;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start[g] = 1'b0;
                idx_i[g] = 8'($urandom);
                idx_j[g] = 8'($urandom);
            end
            if (pulse && n == 3) begin
                start[g] = 1'b1; idx_i[g] = 8'd1; idx_j[g] = 8'd2;
            end
            if (pulse && n == 4) start[g] = 1'b0;
            if (done[g]) begin
                ndone++;
                if (done_at == 0) done_at = n;
            end
            if (wren[g]) begin
                nwr++;
                if (addr[g] != i && addr[g] != j) bad_addr++;
            end
            if (done_at == 0 && !busy[g]) busy_low++;
        end
        chk({tag, " done cycle"}, done_at, exp_done);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " wren cycles"}, nwr, exp_wr);
        chk({tag, " foreign write addr"}, bad_addr, 0);
        chk({tag, " busy dropped early"}, busy_low, 0);
        chk({tag, " busy after"}, int'(busy[g]), 0);
        chk({tag, " wren idle"}, int'(wren[g]), 0);
        chk({tag, " addr idle"}, int'(addr[g]), int'(i));
        chk({tag, " val_i"}, int'(val_i[g]), int'(exp_vi));
        chk({tag, " val_j"}, int'(val_j[g]), int'(exp_vj));
        chk({tag, " sum_out"}, int'(sum_out[g]), int'(exp_sum));
        chk({tag, " s[i]"}, int'(mem[g][i]), int'(exp_mi));
        chk({tag, " s[j]"}, int'(mem[g][j]), int'(exp_mj));
        if (pulse) begin
            chk({tag, " s[1] untouched"}, int'(mem[g][1]), int'(smodel[g][1]));
            chk({tag, " s[2] untouched"}, int'(mem[g][2]), int'(smodel[g][2]));
        end
        smodel[g][i] = exp_mi;
        smodel[g][j] = exp_mj;
    endtask

    typedef struct {
        int         g;
        logic [7:0] i, j, si, sj;
        bit         pulse;
        int         exp_done;
        int         exp_wr;
        logic [7:0] exp_sum;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < NG; g++) begin
            rst[g] = 1'b1; start[g] = 1'b0; idx_i[g] = '0; idx_j[g] = '0;
            for (int a = 0; a < 256; a++) smodel[g][a] = '0;
        end

        vecs[0] = '{0, 8'h03, 8'h07, 8'h50, 8'h12, 1'b0,  9, 2, 8'h62};
        vecs[1] = '{0, 8'h00, 8'hFF, 8'hF0, 8'h20, 1'b0,  9, 2, 8'h10};
        vecs[2] = '{0, 8'h05, 8'h05, 8'h33, 8'h33, 1'b0,  4, 0, 8'h66};
        vecs[3] = '{0, 8'h09, 8'h0A, 8'hAB, 8'hCD, 1'b1,  9, 2, 8'h78};
        vecs[4] = '{1, 8'h03, 8'h07, 8'h50, 8'h12, 1'b0,  7, 2, 8'h62};
        vecs[5] = '{2, 8'h03, 8'h07, 8'h50, 8'h12, 1'b0, 13, 2, 8'h62};
        vecs[6] = '{2, 8'h05, 8'h05, 8'h33, 8'h33, 1'b0, 13, 2, 8'h66};
        vecs[7] = '{1, 8'h08, 8'h08, 8'h44, 8'h44, 1'b0,  3, 0, 8'h88};
        vecs[8] = '{2, 8'hFF, 8'h00, 8'h80, 8'h80, 1'b0, 13, 2, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NG; g++) check_reset_outputs(g, "por");
        for (int g = 0; g < NG; g++) rst[g] = 1'b0;

        // Directed table
        for (int v = 0; v < 9; v++) begin
            poke(vecs[v].g, vecs[v].i, vecs[v].si);
            if (vecs[v].i != vecs[v].j) poke(vecs[v].g, vecs[v].j, vecs[v].sj);
            @(negedge clk);
            run_swap(vecs[v].g, vecs[v].i, vecs[v].j, vecs[v].pulse, vecs[v].exp_done,
                     vecs[v].exp_wr, vecs[v].si, vecs[v].sj, vecs[v].exp_sum,
                     vecs[v].sj, vecs[v].si, $sformatf("vec%0d", v));
        end

        // Reset during WAIT_J on the RD_LAT=2 engine
        poke(0, 8'd20, 8'h11);
        poke(0, 8'd21, 8'h22);
        @(negedge clk);
        start[0] = 1'b1; idx_i[0] = 8'd20; idx_j[0] = 8'd21;
        @(posedge clk);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) start[0] = 1'b0;
            if (n == 5) begin
                chk("rstmid busy before", int'(busy[0]), 1);
                chk("rstmid val_i before", int'(val_i[0]), 8'h11);
                rst[0] = 1'b1;
            end
            if (n == 6) check_reset_outputs(0, "rstmid");
        end
        // Still at the falling edge of cycle 6: release reset and start again
        // so the first edge after release accepts the request.
        chk("rstmid s[20]", int'(mem[0][20]), 8'h11);
        chk("rstmid s[21]", int'(mem[0][21]), 8'h22);
        rst[0] = 1'b0;
        run_swap(0, 8'd20, 8'd21, 1'b0, 9, 2, 8'h11, 8'h22, 8'h33, 8'h22, 8'h11, "postrst");

        // Randomised swaps against the array model
        for (int r = 0; r < 30; r++) begin
            int         g, ed, ew;
            logic [7:0] i, j, vi, vj;
            bit         sk;
            g = $urandom_range(0, 2);
            i = 8'($urandom);
            j = ($urandom_range(0, 3) == 0) ? i : 8'($urandom);
            poke(g, i, 8'($urandom));
            if (i != j) poke(g, j, 8'($urandom));
            vi = smodel[g][i];
            vj = smodel[g][j];
            sk = skip_of(g) && (i == j);
            ed = sk ? 2 + lat_of(g) : 5 + 2 * lat_of(g);
            ew = sk ? 0 : 2;
            @(negedge clk);
            run_swap(g, i, j, 1'b0, ed, ew, vi, vj, 8'(vi + vj), vj, vi,
                     $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
